// File: rtl/chk_pkg.sv
// Shared types and helpers for the end-of-program memory result checker.
// Holds the checker state encoding, the two NOP encodings the idle detector
// recognises, and a saturating increment used by every statistics counter.
package chk_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  // Canonical RV32I NOP (addi x0, x0, 0)
  localparam logic [31:0] NOP_BASE = 32'h00000013;
  // Compressed NOP (c.nop) in the low halfword
  localparam logic [15:0] NOP_C    = 16'h0001;

  // Increment that sticks at the all-ones value of a 'width'-bit counter
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    sat_inc = (value >= max_val) ? max_val : value + 64'd1;
  endfunction

endpackage

// File: rtl/chk_rd_pipe.sv
// Read-latency matching pipe for the result checker.
// Carries a valid bit and the issued word address alongside the memory read,
// so the compare sees the address whose data is arriving this cycle.
module chk_rd_pipe #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
      logic              vld_reg;
      logic [ADDR_W-1:0] addr_reg;
      logic              vld_next;
      logic [ADDR_W-1:0] addr_next;

      if (gi == 0) begin : g_head
        assign vld_next  = in_valid;
        assign addr_next = in_addr;
      end else begin : g_tail
        assign vld_next  = g_stage[gi-1].vld_reg;
        assign addr_next = g_stage[gi-1].addr_reg;
      end

      // One stage of the valid/address delay line; reset empties the pipe
      always_ff @(posedge CLK) begin
        if (rst) begin
          vld_reg  <= 1'b0;
          addr_reg <= '0;
        end else begin
          vld_reg  <= vld_next;
          addr_reg <= addr_next;
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[RD_LAT-1].vld_reg;
  assign out_addr  = g_stage[RD_LAT-1].addr_reg;

endmodule

// File: rtl/mem_result_checker.sv
// End-of-program checker placed behind the rv32imc core.
// Detects program completion from the IF instruction stream (a long run of
// one repeated word, or a shorter run of identical NOPs), then sweeps the
// data-memory console port against an expected-value ROM and reports
// pass/fail counts, the first failing address and the run length.
// Optional build macro CHK_STALL_CNT_EN adds a counter of stalled RUN cycles;
// without it stall_cycles is constant zero and if_stall is ignored.
module mem_result_checker
  import chk_pkg::*;
#(
  parameter int INST_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int SAME_LIMIT = 49,
  parameter int NOP_LIMIT  = 8,
  parameter int RD_LAT     = 1,
  parameter int CNT_W      = 32
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [INST_W-1:0] if_inst,
  input  logic [ADDR_W-1:0] max_addr,
  output logic [ADDR_W-1:0] con_addr,
  input  logic [DATA_W-1:0] con_rdata,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              done,
  output logic              all_pass,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              fail_seen,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [CNT_W-1:0]  run_cycles,
  input  logic              if_stall,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int SC_W = $clog2(SAME_LIMIT + 1);
  localparam int NC_W = $clog2(NOP_LIMIT + 1);
  localparam int DR_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [SC_W-1:0] SAME_LIM_C  = SC_W'(SAME_LIMIT);
  localparam logic [NC_W-1:0] NOP_LIM_C   = NC_W'(NOP_LIMIT);
  localparam logic [DR_W-1:0] DRAIN_END_C = DR_W'(RD_LAT - 1);

  chk_state_t        state_reg;
  logic [INST_W-1:0] last_inst_reg;
  logic [SC_W-1:0]   same_cnt_reg;
  logic [NC_W-1:0]   nop_cnt_reg;
  logic [ADDR_W-1:0] max_q_reg;
  logic [ADDR_W-1:0] con_addr_reg;
  logic [DR_W-1:0]   drain_cnt_reg;
  logic [CNT_W-1:0]  pass_cnt_reg;
  logic [CNT_W-1:0]  fail_cnt_reg;
  logic              fail_seen_reg;
  logic [ADDR_W-1:0] first_fail_reg;
  logic [CNT_W-1:0]  run_cycles_reg;

  logic              is_nop;
  logic              inst_same;
  logic              run_exit;
  logic              pipe_out_valid;
  logic [ADDR_W-1:0] pipe_out_addr;
  logic              word_match;

  assign is_nop    = (if_inst[15:0] == NOP_C) || (if_inst == INST_W'(NOP_BASE));
  assign inst_same = (if_inst == last_inst_reg);
  // Exit decision uses the registered counts, so it lands one edge after the limit is reached
  assign run_exit  = (state_reg == RUN) &&
                     ((same_cnt_reg == SAME_LIM_C) || (nop_cnt_reg == NOP_LIM_C));
  assign word_match = (con_rdata == exp_data);

  chk_rd_pipe #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .CLK       (CLK),
    .rst       (rst),
    .in_valid  (state_reg == SWEEP),
    .in_addr   (con_addr_reg),
    .out_valid (pipe_out_valid),
    .out_addr  (pipe_out_addr)
  );

  // Phase sequencing and sweep address generation; the exit test precedes the increment so addresses never wrap
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_reg     <= RUN;
      max_q_reg     <= '0;
      con_addr_reg  <= '0;
      drain_cnt_reg <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (run_exit) begin
            state_reg    <= SWEEP;
            max_q_reg    <= max_addr;
            con_addr_reg <= '0;
          end
        end
        SWEEP: begin
          if (con_addr_reg == max_q_reg) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= '0;
          end else begin
            con_addr_reg <= con_addr_reg + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == DRAIN_END_C) begin
            state_reg <= DONE;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + DR_W'(1);
          end
        end
        DONE: begin
          state_reg <= DONE;
        end
        default: begin
          state_reg <= RUN;
        end
      endcase
    end
  end

  // Idle detector: length of the current run of identical fetched words, and of identical NOPs
  always_ff @(posedge CLK) begin
    if (rst) begin
      last_inst_reg <= '0;
      same_cnt_reg  <= '0;
      nop_cnt_reg   <= '0;
    end else if ((state_reg == RUN) && !run_exit) begin
      if (inst_same) begin
        same_cnt_reg <= same_cnt_reg + SC_W'(1);
        if (is_nop) begin
          nop_cnt_reg <= nop_cnt_reg + NC_W'(1);
        end
      end else begin
        last_inst_reg <= if_inst;
        same_cnt_reg  <= '0;
        nop_cnt_reg   <= '0;
      end
    end
  end

  // Compare each retiring read and accumulate pass/fail statistics
  always_ff @(posedge CLK) begin
    if (rst) begin
      pass_cnt_reg   <= '0;
      fail_cnt_reg   <= '0;
      fail_seen_reg  <= 1'b0;
      first_fail_reg <= '0;
    end else if (pipe_out_valid) begin
      if (word_match) begin
        pass_cnt_reg <= CNT_W'(sat_inc(64'(pass_cnt_reg), CNT_W));
      end else begin
        fail_cnt_reg <= CNT_W'(sat_inc(64'(fail_cnt_reg), CNT_W));
        if (!fail_seen_reg) begin
          fail_seen_reg  <= 1'b1;
          first_fail_reg <= pipe_out_addr;
        end
      end
    end
  end

  // Count every cycle spent in RUN, including the exit cycle
  always_ff @(posedge CLK) begin
    if (rst) begin
      run_cycles_reg <= '0;
    end else if (state_reg == RUN) begin
      run_cycles_reg <= CNT_W'(sat_inc(64'(run_cycles_reg), CNT_W));
    end
  end

`ifdef CHK_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  // Count RUN cycles in which the core reported an IF stall
  always_ff @(posedge CLK) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg == RUN) && if_stall) begin
      stall_cnt_reg <= CNT_W'(sat_inc(64'(stall_cnt_reg), CNT_W));
    end
  end

  assign stall_cycles = stall_cnt_reg;
`else
  logic unused_if_stall;
  assign unused_if_stall = if_stall;
  assign stall_cycles    = '0;
`endif

  assign con_addr        = con_addr_reg;
  assign exp_addr        = con_addr_reg;
  assign done            = (state_reg == DONE);
  assign all_pass        = done && (fail_cnt_reg == '0);
  assign pass_cnt        = pass_cnt_reg;
  assign fail_cnt        = fail_cnt_reg;
  assign fail_seen       = fail_seen_reg;
  assign first_fail_addr = first_fail_reg;
  assign run_cycles      = run_cycles_reg;

endmodule

// File: tb/tb_mem_result_checker.sv
// Randomized scoreboard bench for mem_result_checker.
// Stimulus builds an instruction stream plus memory/ROM contents, predicts the
// run outcome from the completion rules and pushes it into a queue; a monitor
// pops and compares when done rises, using a per-cycle trace of con_addr.
module tb_mem_result_checker;

  localparam int INST_W     = 32;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int SAME_LIMIT = 49;
  localparam int NOP_LIMIT  = 8;
  localparam int RD_LAT     = 1;
  localparam int CNT_W      = 32;
  localparam int MAXL       = 256;
  localparam int BUDGET     = 3000;
  localparam int TRACE_N    = 4096;

  logic              CLK = 1'b0;
  logic              rst = 1'b1;
  logic [INST_W-1:0] if_inst = '0;
  logic [ADDR_W-1:0] max_addr = '0;
  logic [ADDR_W-1:0] con_addr;
  logic [DATA_W-1:0] con_rdata;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              done;
  logic              all_pass;
  logic [CNT_W-1:0]  pass_cnt;
  logic [CNT_W-1:0]  fail_cnt;
  logic              fail_seen;
  logic [ADDR_W-1:0] first_fail_addr;
  logic [CNT_W-1:0]  run_cycles;
  logic              if_stall = 1'b0;
  logic [CNT_W-1:0]  stall_cycles;

  always #5 CLK = ~CLK;

  mem_result_checker #(
    .INST_W(INST_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SAME_LIMIT(SAME_LIMIT),
    .NOP_LIMIT(NOP_LIMIT), .RD_LAT(RD_LAT), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .rst(rst), .if_inst(if_inst), .max_addr(max_addr),
    .con_addr(con_addr), .con_rdata(con_rdata), .exp_addr(exp_addr), .exp_data(exp_data),
    .done(done), .all_pass(all_pass), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .fail_seen(fail_seen), .first_fail_addr(first_fail_addr), .run_cycles(run_cycles),
    .if_stall(if_stall), .stall_cycles(stall_cycles)
  );

  // Memory and ROM models with RD_LAT-cycle registered reads
  logic [DATA_W-1:0] mem [1024];
  logic [DATA_W-1:0] rom [1024];
  logic [DATA_W-1:0] rdat_pipe [RD_LAT];
  logic [DATA_W-1:0] edat_pipe [RD_LAT];

  always @(posedge CLK) begin
    rdat_pipe[0] <= mem[con_addr];
    edat_pipe[0] <= rom[exp_addr];
    for (int i = 1; i < RD_LAT; i++) begin
      rdat_pipe[i] <= rdat_pipe[i-1];
      edat_pipe[i] <= edat_pipe[i-1];
    end
  end
  assign con_rdata = rdat_pipe[RD_LAT-1];
  assign exp_data  = edat_pipe[RD_LAT-1];

  // Edges since reset release
  int cyc = 0;
  always @(posedge CLK) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int          run_r;
    int          max_a;
    int          done_cyc;
    logic [63:0] pass;
    logic [63:0] fail;
    logic        seen;
    logic [63:0] first;
    logic [63:0] stall;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0] prog [0:MAXL];
  logic        stl  [0:MAXL];
  int          tr_con [TRACE_N];
  int          tr_exp [TRACE_N];

  // ---------------- reference model ----------------
  function automatic bit is_nop(input logic [31:0] w);
    return (w[15:0] == 16'h0001) || (w == 32'h00000013);
  endfunction

  function automatic bit window_equal(input int lo, input int hi);
    for (int j = lo + 1; j <= hi; j++)
      if (prog[j] != prog[lo]) return 1'b0;
    return 1'b1;
  endfunction

  // The run ends at edge t when the words fed at edges t-1-LIMIT..t-1 are all identical
  // (index 0 stands for the cleared last-instruction register).
  function automatic int model_exit();
    for (int t = 1; t <= MAXL; t++) begin
      if (t - 1 - SAME_LIMIT >= 0 && window_equal(t - 1 - SAME_LIMIT, t - 1)) return t;
      if (t - 1 - NOP_LIMIT >= 0 && is_nop(prog[t-1]) && window_equal(t - 1 - NOP_LIMIT, t - 1)) return t;
    end
    return 0;
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (cyc < TRACE_N) begin
        tr_con[cyc] = int'(con_addr);
        tr_exp[cyc] = int'(exp_addr);
      end
      if (done && !done_prev) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'(0));
        end else begin
          e = sb_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.done_cyc));
          check("run_cycles", 64'(run_cycles), 64'(e.run_r));
          check("pass_cnt", 64'(pass_cnt), e.pass);
          check("fail_cnt", 64'(fail_cnt), e.fail);
          check("fail_seen", 64'(fail_seen), 64'(e.seen));
          check("first_fail_addr", 64'(first_fail_addr), e.first);
          check("all_pass", 64'(all_pass), 64'(e.fail == 0));
          check("stall_cycles", 64'(stall_cycles), e.stall);
          check("con_addr_hold", 64'(con_addr), 64'(e.max_a));
          for (int k = 0; k <= e.max_a; k++) begin
            if (e.run_r + k < TRACE_N) begin
              check("con_addr_seq", 64'(tr_con[e.run_r + k]), 64'(k));
              check("exp_addr_seq", 64'(tr_exp[e.run_r + k]), 64'(k));
            end
          end
        end
      end
      done_prev = done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic gen_const(input logic [31:0] w);
    prog[0] = 32'h0;
    stl[0]  = 1'b0;
    for (int t = 1; t <= MAXL; t++) begin
      prog[t] = w;
      stl[t]  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic gen_random();
    int p;
    int kind;
    logic [31:0] w;
    p    = $urandom_range(0, 40);
    kind = $urandom_range(0, 2);
    case (kind)
      0:       w = 32'h00000013;
      1:       w = {16'($urandom), 16'h0001};
      default: w = $urandom;
    endcase
    gen_const(w);
    for (int t = 1; t <= p; t++) prog[t] = $urandom;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      rom[i] = mem[i];
    end
  endtask

  task automatic corrupt(input int a);
    rom[a] = rom[a] ^ (32'($urandom_range(1, 32'hFFFF)) << 4);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_con_addr"}, 64'(con_addr), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_all_pass"}, 64'(all_pass), 64'(0));
    check({tag, "_pass_cnt"}, 64'(pass_cnt), 64'(0));
    check({tag, "_fail_cnt"}, 64'(fail_cnt), 64'(0));
    check({tag, "_fail_seen"}, 64'(fail_seen), 64'(0));
    check({tag, "_first_fail"}, 64'(first_fail_addr), 64'(0));
    check({tag, "_run_cycles"}, 64'(run_cycles), 64'(0));
    check({tag, "_stall"}, 64'(stall_cycles), 64'(0));
  endtask

  // One program run; abort_at >= 0 pulses rst when that sweep address is seen
  task automatic do_run(input int run_id, input int maxa, input int abort_at);
    int   r;
    exp_t e;
    bit   got;
    bit   aborted;
    @(negedge CLK);
    rst      = 1'b1;
    if_inst  = '0;
    if_stall = 1'b0;
    max_addr = ADDR_W'(maxa);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    r = model_exit();
    if (r == 0) r = MAXL;
    e.run_r    = r;
    e.max_a    = maxa;
    e.done_cyc = r + maxa + 1 + RD_LAT;
    e.pass     = 0;
    e.fail     = 0;
    e.seen     = 1'b0;
    e.first    = 0;
    for (int k = 0; k <= maxa; k++) begin
      if (mem[k] == rom[k]) e.pass++;
      else begin
        e.fail++;
        if (!e.seen) begin
          e.seen  = 1'b1;
          e.first = 64'(k);
        end
      end
    end
    e.stall = 0;
`ifdef CHK_STALL_CNT_EN
    for (int t = 1; t <= r; t++) e.stall += 64'(stl[t]);
`endif
    if (abort_at < 0) sb_q.push_back(e);
    $display("run %0d: exit_edge=%0d max_addr=%0d exp_pass=%0d exp_fail=%0d abort_at=%0d",
             run_id, r, maxa, e.pass, e.fail, abort_at);
    rst     = 1'b0;
    got     = 1'b0;
    aborted = 1'b0;
    for (int t = 1; t <= BUDGET && !got && !aborted; t++) begin
      if (t <= MAXL) begin
        if_inst  = prog[t];
        if_stall = stl[t];
      end else begin
        if_inst  = $urandom;
        if_stall = 1'($urandom_range(0, 1));
      end
      if (t == r + 1) max_addr = ADDR_W'($urandom);
      @(posedge CLK);
      @(negedge CLK);
      if (abort_at >= 0 && cyc > r && int'(con_addr) == abort_at) begin
        rst = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        reset_checks("midsweep_rst");
        aborted = 1'b1;
      end else if (done) begin
        got = 1'b1;
      end
    end
    if (!got && !aborted) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: run %0d got no done within %0d cycles, required done=1", run_id, BUDGET);
      if (abort_at < 0 && sb_q.size() > 0) void'(sb_q.pop_back());
    end
    @(negedge CLK);
  endtask

  initial begin : stimulus
    int maxa;
    int nbad;
    init_mem();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    reset_checks("reset");

    // NOP stream, clean memory, ten words
    gen_const(32'h00000013);
    init_mem();
    do_run(0, 9, -1);

    // Jump-to-self with a break at repeat 30, two mismatches
    gen_const(32'h0000006F);
    prog[31] = 32'h00000093;
    init_mem();
    corrupt(3);
    corrupt(7);
    do_run(1, 9, -1);

    // Reset in the middle of a sweep
    gen_const(32'h00000013);
    init_mem();
    do_run(2, 9, 5);

    // Single-word sweep
    gen_const(32'h00000013);
    init_mem();
    do_run(3, 0, -1);

    // Exactly twelve stalled RUN cycles on a plain jump-to-self stream
    gen_const(32'h0000006F);
    for (int t = 1; t <= MAXL; t++) stl[t] = (t >= 3 && t <= 14);
    init_mem();
    corrupt(0);
    do_run(4, 20, -1);

    // Randomized programs, sizes and mismatch sets (some beyond max_addr)
    for (int n = 0; n < 8; n++) begin
      gen_random();
      init_mem();
      maxa = $urandom_range(0, 40);
      nbad = $urandom_range(0, 3);
      for (int b = 0; b < nbad; b++) corrupt($urandom_range(0, maxa + 5));
      do_run(5 + n, maxa, -1);
    end

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_result_checker.md
Name: mem_result_checker

Overview:
Synthesizable end-of-program checker that sits downstream of the rv32imc core.
- Watches the fetched instruction stream and detects program completion: the same instruction repeating, or a run of NOPs.
- Then sweeps the core's console read port over data memory and compares each word against an expected-value ROM.
- Produces pass/fail counts, the first failing address and the run-cycle count, for FPGA self-test without a simulator.

Parameters:
- INST_W, 32, fetched instruction width
- ADDR_W, 10, console/expected-ROM word address width
- DATA_W, 32, data word width
- SAME_LIMIT, 49, consecutive identical instructions that end the run
- NOP_LIMIT, 8, consecutive identical NOPs that end the run
- RD_LAT, 1, read latency in cycles of con_rdata and exp_data after address issue (1..4)
- CNT_W, 32, width of all statistics counters

Ports:
- CLK  in  1  system clock
- rst  in  1  synchronous, active-high reset
- if_inst  in  INST_W  instruction currently in the IF stage
- max_addr  in  ADDR_W  last word address to check (inclusive)
- con_addr  out  ADDR_W  data-memory console read address
- con_rdata  in  DATA_W  data-memory console read data, RD_LAT cycles after con_addr
- exp_addr  out  ADDR_W  expected-ROM address; always equal to con_addr
- exp_data  in  DATA_W  expected word, RD_LAT cycles after exp_addr
- done  out  1  sweep complete, results valid
- all_pass  out  1  done and fail_cnt==0
- pass_cnt  out  CNT_W  matching words
- fail_cnt  out  CNT_W  mismatching words
- fail_seen  out  1  at least one mismatch recorded
- first_fail_addr  out  ADDR_W  address of the first mismatch
- run_cycles  out  CNT_W  cycles spent in RUN
- if_stall  in  1  core IF stall (used only with CHK_STALL_CNT_EN)
- stall_cycles  out  CNT_W  stalled RUN cycles (0 without the macro)

Behaviour:
- Synchronous, active-high reset is decided.
  - rst=1 at any clock edge forces state RUN and clears all outputs, counters, last_inst, same_cnt, nop_cnt and the valid pipeline.
  - This applies mid-sweep as well; rst overrides every other event in the same cycle.
- States: RUN -> SWEEP -> DRAIN -> DONE. DONE is held until rst.
- RUN:
  - A NOP is if_inst[15:0]==16'h0001 or if_inst==32'h00000013.
  - If if_inst==last_inst: same_cnt+1; also nop_cnt+1 when the word is a NOP.
  - Otherwise last_inst<=if_inst and same_cnt=nop_cnt=0.
  - run_cycles+1 every RUN cycle.
  - Exit to SWEEP on the edge where the registered same_cnt==SAME_LIMIT or nop_cnt==NOP_LIMIT.
  - On exit: latch max_addr into max_q and set con_addr=0.
- SWEEP:
  - Each cycle: push {valid=1, con_addr} into an RD_LAT-deep shift register, then con_addr+1.
  - When con_addr==max_q is issued, go to DRAIN; con_addr holds its value.
  - max_q==0 gives exactly one compare.
  - Addresses never wrap: max_q is at most 2^ADDR_W-1, and the exit test precedes the increment.
- DRAIN: push valid=0 for RD_LAT cycles; enter DONE on the cycle after the last valid compare retires.
- Compare, in any state, when the pipeline output is valid:
  - con_rdata==exp_data: pass_cnt+1.
  - Otherwise fail_cnt+1. If fail_seen==0, set fail_seen=1 and first_fail_addr=the pipelined address.
- Counters saturate at all-ones and never wrap.
- done=1 only in DONE; all_pass is combinational from done and fail_cnt.
- if_inst is ignored outside RUN.
- Latency: first compare RD_LAT cycles after entering SWEEP. Total SWEEP+DRAIN = max_q+1+RD_LAT cycles.

Optional Feature:
- Macro: CHK_STALL_CNT_EN.
- Defined: stall_cycles+1 (saturating) on each RUN cycle with if_stall=1; cleared by rst.
- Undefined: no counter logic is generated, stall_cycles is tied to 0, and if_stall is unused.

Decomposition:
- Shared package chk_pkg:
  - state enum {RUN, SWEEP, DRAIN, DONE}
  - NOP_BASE = 32'h00000013
  - NOP_C = 16'h0001
  - saturating-increment function
- One sub-module, chk_rd_pipe: RD_LAT-deep valid+address shift register. The top holds the FSM, the idle detector and the counters.

Test Plan:
- Stream 0x00000013 repeated: enters SWEEP on the edge after the eighth repeat (nop_cnt==8); run_cycles equals RUN cycles counted by the bench.
- Jump-to-self 0x0000006F repeated: SWEEP entered after same_cnt reaches 49; a non-repeating word at repeat 30 restarts the count from 0.
- max_addr=9, RD_LAT=1, memory==ROM: con_addr 0..9 in 10 consecutive cycles; done after 11 cycles from SWEEP entry; pass_cnt=10, fail_cnt=0, all_pass=1.
- ROM differs at addresses 3 and 7: fail_cnt=2, pass_cnt=8, first_fail_addr=3, fail_seen=1, all_pass=0.
- rst pulsed mid-SWEEP at con_addr=5: all outputs clear next cycle and state=RUN. A second run with max_addr=0 does one compare and done=1 two cycles after SWEEP entry.
- With CHK_STALL_CNT_EN and if_stall high for 12 RUN cycles: stall_cycles=12; without the macro, stall_cycles=0.
